// File: rtl/cell_tb_pkg.sv
// rtl/cell_tb_pkg.sv - shared FSM state type, width helper and standard-cell truth tables
package cell_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Truth tables indexed by {A,B1,B2}; bit i is ZN for vector i.
  localparam logic [7:0] AOI21_TT = 8'h07;
  localparam logic [7:0] OAI21_TT = 8'h1F;
  localparam logic [7:0] NAND3_TT = 8'h7F;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vec_phase_timer.sv
// rtl/vec_phase_timer.sv - phase down-counter; expired while the count sits at zero
module vec_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] load_val,
  input  logic         load,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && !expired) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cell3_vector_sequencer.sv
// rtl/cell3_vector_sequencer.sv - sweeps all cell input vectors, samples ZN after a settle
// window and scores it against a truth table.
module cell3_vector_sequencer
  import cell_tb_pkg::*;
#(
  parameter int                        N_IN       = 3,
  parameter int                        GAP_CYC    = 5,
  parameter int                        SETTLE_CYC = 10,
  parameter logic [(1 << N_IN) - 1:0]  EXP_TT     = AOI21_TT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_zn,
  output logic            busy,
  output logic            sample_valid,
  output logic [N_IN-1:0] sample_idx,
  output logic            sample_val,
  output logic            mismatch,
  output logic [N_IN:0]   err_cnt,
  output logic            done,
  output logic            pass
);

  localparam int              NV          = 1 << N_IN;
  localparam int              TMAX        = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
  localparam int              TW          = clog2(TMAX + 1);
  localparam logic [TW-1:0]   GAP_LOAD    = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(NV - 1);
  localparam logic [N_IN:0]   ERR_MAX     = (N_IN + 1)'(NV);

  state_e          state_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            sample_valid_q;
  logic [N_IN-1:0] sample_idx_q;
  logic            sample_val_q;
  logic            mismatch_q;
  logic [N_IN:0]   err_q;
  logic            done_q;
  logic            pass_q;

  logic            timer_load;
  logic            timer_tick;
  logic [TW-1:0]   timer_val;
  logic            timer_expired;
  logic            mis_now;
  logic [N_IN:0]   err_d;

  // Case inequality so an X or Z on the cell output is scored as a failure.
  assign mis_now = (dut_zn !== EXP_TT[idx_q]);
  assign err_d   = (mis_now && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

  always_comb begin
    timer_load = 1'b0;
    timer_tick = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (timer_expired) begin
          timer_load = 1'b1;
          timer_val  = SETTLE_LOAD;
        end else begin
          timer_tick = 1'b1;
        end
      end
      ST_SETTLE: timer_tick = !timer_expired;
      ST_SAMPLE: begin
        if (idx_q != LAST_IDX) begin
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end
      end
      default: ;
    endcase
  end

  vec_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_val (timer_val),
    .load     (timer_load),
    .tick     (timer_tick),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      vec_q          <= '0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_idx_q   <= '0;
      sample_val_q   <= 1'b0;
      mismatch_q     <= 1'b0;
      err_q          <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_GAP;
            idx_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_expired) begin
            state_q <= ST_SETTLE;
            vec_q   <= idx_q;
          end
        end
        ST_SETTLE: begin
          if (timer_expired) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          sample_valid_q <= 1'b1;
          sample_idx_q   <= idx_q;
          sample_val_q   <= dut_zn;
          mismatch_q     <= mis_now;
          err_q          <= err_d;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= ST_GAP;
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_idx   = sample_idx_q;
  assign sample_val   = sample_val_q;
  assign mismatch     = mismatch_q;
  assign err_cnt      = err_q;
  assign done         = done_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_cell3_vector_sequencer.sv
// tb/tb_cell3_vector_sequencer.sv - scoreboard bench for cell3_vector_sequencer
module tb_cell3_vector_sequencer;

  typedef struct packed {
    logic [2:0] idx;
    logic       val;
    logic       care;
    logic       mis;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] vec_out, sample_idx, vec_out2, sample_idx2;
  logic       dut_zn, busy, sample_valid, sample_val, mismatch, done, pass;
  logic       dut_zn2, busy2, sample_valid2, sample_val2, mismatch2, done2, pass2;
  logic [3:0] err_cnt, err_cnt2;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   mode = 0;
  rec_t q1[$];
  rec_t q2[$];
  logic xv;
  logic x_inj;
  logic [3:0] dly = 4'hF;
  logic [15:0] outs1;

  cell3_vector_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out), .dut_zn(dut_zn),
    .busy(busy), .sample_valid(sample_valid), .sample_idx(sample_idx),
    .sample_val(sample_val), .mismatch(mismatch), .err_cnt(err_cnt),
    .done(done), .pass(pass)
  );

  cell3_vector_sequencer #(.SETTLE_CYC(2)) u_slow (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_out(vec_out2), .dut_zn(dut_zn2),
    .busy(busy2), .sample_valid(sample_valid2), .sample_idx(sample_idx2),
    .sample_val(sample_val2), .mismatch(mismatch2), .err_cnt(err_cnt2),
    .done(done2), .pass(pass2)
  );

  function automatic logic aoi21(input logic [2:0] v);
    return ~(v[2] | (v[1] & v[0]));
  endfunction

  // An unknown that, if a two-state simulator resolves it, resolves to the wrong value.
  initial xv = 1'bx;
  assign x_inj = (xv === 1'b0) ? 1'b1 : xv;

  always_comb begin
    dut_zn = aoi21(vec_out);
    if (mode == 1) dut_zn = 1'b0;
    else if (mode == 2 && vec_out == 3'd5) dut_zn = x_inj;
  end

  always @(posedge clk) dly <= {dly[2:0], aoi21(vec_out2)};
  assign dut_zn2 = dly[3];

  assign outs1 = {vec_out, busy, sample_valid, sample_idx, sample_val, mismatch, err_cnt, done, pass};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    rec_t r;
    if (rst_n === 1'b1 && sample_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL sb1_unexpected: got sample idx %0d expected none", sample_idx);
      end else begin
        r = q1.pop_front();
        chk("sb1_sample_idx", 32'(sample_idx), 32'(r.idx));
        chk("sb1_vec_out", 32'(vec_out), 32'(r.idx));
        chk("sb1_mismatch", 32'(mismatch), 32'(r.mis));
        if (r.care) chk("sb1_sample_val", 32'(sample_val), 32'(r.val));
      end
    end
  end

  always @(negedge clk) begin : mon2
    rec_t r;
    if (rst_n === 1'b1 && sample_valid2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL sb2_unexpected: got sample idx %0d expected none", sample_idx2);
      end else begin
        r = q2.pop_front();
        chk("sb2_sample_idx", 32'(sample_idx2), 32'(r.idx));
        chk("sb2_vec_out", 32'(vec_out2), 32'(r.idx));
        chk("sb2_mismatch", 32'(mismatch2), 32'(r.mis));
        chk("sb2_sample_val", 32'(sample_val2), 32'(r.val));
      end
    end
  end

  task automatic run1(input string tag, input int m, input logic [7:0] vals, input logic [7:0] mis,
                      input logic [7:0] care, input int exp_err, input logic exp_pass,
                      input int repulse_at, input int abort_at);
    int done_at;
    done_at = 0;
    mode = m;
    for (int i = 0; i < 8; i++) q1.push_back('{idx: 3'(i), val: vals[i], care: care[i], mis: mis[i]});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_err_cleared"}, 32'(err_cnt), 32'd0);
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
    for (int k = 1; k <= 200 && done_at == 0; k++) begin
      start = (k == repulse_at);
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1 chk({tag, "_async_reset_outputs"}, 32'(outs1), 32'd0);
        q1.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (done === 1'b1) done_at = k;
    end
    chk({tag, "_done_latency"}, done_at, 128);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk({tag, "_sb_drained"}, q1.size(), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", 32'(outs1), 32'd0);
    chk("reset_slow_busy_done", 32'({busy2, done2, err_cnt2}), 32'd0);
    rst_n = 1'b1;

    run1("t1_good",    0, 8'h07, 8'h00, 8'hFF, 0, 1'b1, 0, 0);
    run1("t2_stuck0",  1, 8'h00, 8'h07, 8'hFF, 3, 1'b0, 0, 0);
    run1("t4_repulse", 0, 8'h07, 8'h00, 8'hFF, 0, 1'b1, 20, 0);
    run1("t3_abort",   0, 8'h07, 8'h00, 8'hFF, 0, 1'b1, 0, 50);
    run1("t3_rerun",   0, 8'h07, 8'h00, 8'hFF, 0, 1'b1, 0, 0);
    run1("t6_xinj",    2, 8'h07, 8'h20, 8'hDF, 1, 1'b0, 0, 0);

    // Short settle against a slow cell: each sample still sees the previous vector's ZN.
    begin
      int done_at;
      logic [7:0] v2, m2;
      done_at = 0;
      v2 = 8'h0F;
      m2 = 8'h08;
      for (int i = 0; i < 8; i++) q2.push_back('{idx: 3'(i), val: v2[i], care: 1'b1, mis: m2[i]});
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int k = 1; k <= 200 && done_at == 0; k++) begin
        @(posedge clk); #1;
        if (done2 === 1'b1) done_at = k;
      end
      chk("t5_done_latency", done_at, 64);
      chk("t5_err_cnt", 32'(err_cnt2), 32'd1);
      chk("t5_pass", 32'(pass2), 32'd0);
      @(negedge clk); #1;
      chk("t5_sb_drained", q2.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
